// File: rtl/icache_axi_refill.sv
// I-cache line-refill master: one two-beat INCR AXI read per miss, assembled into a 128-bit line.
// Optional error reporting (refill_err port) is enabled by defining ICACHE_REFILL_ERR_EN.
module icache_axi_refill #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // upstream miss request / refill write port
    input  logic                  miss_req,
    input  logic [ADDR_W-1:0]     miss_addr,
    output logic                  miss_ready,
    output logic                  refill_valid,
    output logic [ADDR_W-1:0]     refill_addr,
    output logic [2*BEAT_W-1:0]   refill_line,
`ifdef ICACHE_REFILL_ERR_EN
    output logic                  refill_err,
`endif
    // AXI read address channel
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic                  arready,
    // AXI read data channel
    input  logic [BEAT_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    input  logic                  rlast,
    output logic                  rready,
    // debug view of the FSM state
    output logic [2:0]            dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never drops and its payload never changes until that edge.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R0   = 3'd2,
        S_R1   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [2*BEAT_W-1:0]   line_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (miss_req) state_d = S_AR;
            S_AR:    if (arready)  state_d = S_R0;
            S_R0:    if (rvalid)   state_d = rlast ? S_DONE : S_R1;
            S_R1:    if (rvalid)   state_d = S_DONE;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        miss_ready   = (state_q == S_IDLE);
        arvalid      = (state_q == S_AR);
        rready       = (state_q == S_R0) || (state_q == S_R1);
        refill_valid = (state_q == S_DONE);
    end

    // An early rlast on the first beat zeroes the upper half so no stale beat leaks out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            line_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (miss_req) addr_q <= {miss_addr[ADDR_W-1:4], 4'b0000};
                S_R0: if (rvalid) begin
                    line_q[BEAT_W-1:0] <= rdata;
                    if (rlast) line_q[2*BEAT_W-1:BEAT_W] <= '0;
                end
                S_R1: if (rvalid) line_q[2*BEAT_W-1:BEAT_W] <= rdata;
                default: ;
            endcase
        end
    end

`ifdef ICACHE_REFILL_ERR_EN
    logic err_q;
    logic unused_addr_lsb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (miss_req) err_q <= 1'b0;
                S_R0: if (rvalid && (rresp != 2'b00 || rlast)) err_q <= 1'b1;
                S_R1: if (rvalid && (rresp != 2'b00 || !rlast)) err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Hidden while a burst is in flight so only the finished refill's status is visible.
    assign refill_err      = err_q && ((state_q == S_DONE) || (state_q == S_IDLE));
    assign unused_addr_lsb = ^miss_addr[3:0];
`else
    logic unused_inputs;
    assign unused_inputs = ^{rresp, miss_addr[3:0]};
`endif

    assign araddr      = addr_q;
    assign refill_addr = addr_q;
    assign refill_line = line_q;
    assign arlen       = 8'd1;
    assign arsize      = 3'b011;
    assign arburst     = 2'b01;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Self-checking bench for icache_axi_refill: directed and randomized refills against a latency/line model.
module tb_icache_axi_refill;

    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;

    logic                clk;
    logic                rst_n;
    logic                miss_req;
    logic [ADDR_W-1:0]   miss_addr;
    logic                miss_ready;
    logic                refill_valid;
    logic [ADDR_W-1:0]   refill_addr;
    logic [2*BEAT_W-1:0] refill_line;
`ifdef ICACHE_REFILL_ERR_EN
    logic                refill_err;
`endif
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arready;
    logic [BEAT_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rlast;
    logic                rready;
    logic [2:0]          dbg_state;

    icache_axi_refill #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .refill_valid (refill_valid),
        .refill_addr  (refill_addr),
        .refill_line  (refill_line),
`ifdef ICACHE_REFILL_ERR_EN
        .refill_err   (refill_err),
`endif
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rlast        (rlast),
        .rready       (rready),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [127:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss_req = 1'b0;
        arready  = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rresp    = 2'b00;
    endtask

    // One refill: the model predicts line, address, error and strobe latency from the slave timing.
    task automatic run_miss(input logic [31:0] addr, input int ar_wait, input int gap0, input int gap1,
                            input logic [63:0] b0, input logic [63:0] b1,
                            input logic [1:0] r0, input logic [1:0] r1,
                            input bit early, input bit nolast, input bit noise);
        logic [31:0]  exp_addr;
        logic [127:0] exp_line;
        logic [127:0] got_line;
        int           exp_lat;
        bit           exp_err;
        int           cyc;
        int           ar_cnt;
        int           bi;
        int           g;
        bit           done;
        exp_addr = addr & 32'hFFFF_FFF0;
        exp_line = early ? {64'h0, b0} : {b1, b0};
        exp_lat  = early ? (3 + ar_wait + gap0) : (4 + ar_wait + gap0 + gap1);
        exp_err  = (r0 != 2'b00) || early || (!early && (r1 != 2'b00 || nolast));
        exp_q.push_back(exp_line);

        chk("miss_ready_idle", {127'h0, miss_ready}, 128'h1);
        miss_req  = 1'b1;
        miss_addr = addr;
        step();
        miss_req = 1'b0;
        cyc = 0; ar_cnt = 0; bi = 0; g = 0; done = 0;
        while (!done && cyc < 60) begin
            cyc++;
`ifdef ICACHE_REFILL_ERR_EN
            if (cyc == 1) chk("err_cleared_on_accept", {127'h0, refill_err}, 128'h0);
`endif
            if (refill_valid) begin
                done = 1;
                got_line = exp_q.pop_front();
                chk("strobe_latency", 128'(cyc), 128'(exp_lat));
                chk("refill_line", refill_line, got_line);
                chk("refill_addr", {96'h0, refill_addr}, {96'h0, exp_addr});
`ifdef ICACHE_REFILL_ERR_EN
                chk("refill_err", {127'h0, refill_err}, {127'h0, exp_err});
`endif
                idle_inputs();
                step();
            end else begin
                if (arvalid) begin
                    chk("araddr_stable", {96'h0, araddr}, {96'h0, exp_addr});
                    if (ar_cnt == 0) chk("ar_consts", {115'h0, arlen, arsize, arburst}, {115'h0, 8'd1, 3'b011, 2'b01});
                    arready = (ar_cnt == ar_wait);
                    ar_cnt++;
                end else begin
                    arready = 1'b0;
                end
                if (rready) begin
                    if (g == (bi == 0 ? gap0 : gap1)) begin
                        rvalid = 1'b1;
                        rdata  = (bi == 0) ? b0 : b1;
                        rresp  = (bi == 0) ? r0 : r1;
                        rlast  = (bi == 0) ? early : !nolast;
                        bi++;
                        g = 0;
                    end else begin
                        rvalid = 1'b0;
                        rdata  = {$urandom, $urandom};
                        g++;
                    end
                end else begin
                    rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    rdata  = {$urandom, $urandom};
                    rlast  = 1'($urandom_range(0, 1));
                    rresp  = 2'($urandom_range(0, 3));
                end
                if (noise) begin
                    miss_req  = 1'($urandom_range(0, 1));
                    miss_addr = $urandom;
                end
                step();
            end
        end
        if (!done) void'(exp_q.pop_front());
        chk("refill_done", {127'h0, done}, 128'h1);
        // cycle after the strobe: strobe gone, results held, ready for the next miss
        chk("strobe_one_cycle", {127'h0, refill_valid}, 128'h0);
        chk("line_held", refill_line, exp_line);
        chk("addr_held", {96'h0, refill_addr}, {96'h0, exp_addr});
`ifdef ICACHE_REFILL_ERR_EN
        chk("err_held", {127'h0, refill_err}, {127'h0, exp_err});
`endif
    endtask

    initial begin
        logic [31:0] ra;
        rst_n     = 1'b0;
        miss_addr = '0;
        rdata     = '0;
        idle_inputs();

        // reset state, constants visible during reset
        step();
        step();
        chk("rst_consts", {115'h0, arlen, arsize, arburst}, {115'h0, 8'd1, 3'b011, 2'b01});
        chk("rst_ctrl", {124'h0, miss_ready, arvalid, rready, refill_valid}, {124'h0, 4'b1000});
        chk("rst_line", refill_line, 128'h0);
        chk("rst_addrs", {64'h0, araddr, refill_addr}, 128'h0);
`ifdef ICACHE_REFILL_ERR_EN
        chk("rst_err", {127'h0, refill_err}, 128'h0);
`endif
        rst_n = 1'b1;
        step();

        // zero-wait reference refill
        run_miss(32'h8000_001C, 0, 0, 0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 2'b00, 2'b00, 0, 0, 0);
        // arready low for three cycles
        run_miss(32'h1234_5678, 3, 0, 0, 64'hAAAA_0000_5555_0001, 64'hBBBB_0000_6666_0002, 2'b00, 2'b00, 0, 0, 0);
        // two-cycle rvalid gap between beats
        run_miss(32'h0000_0FF3, 0, 0, 2, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 2'b00, 2'b00, 0, 0, 0);
        // busy-time miss pulses and stray rvalid, then a back-to-back miss
        run_miss(32'h4000_0044, 1, 1, 1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b00, 2'b00, 0, 0, 1);
        run_miss(32'h4000_0100, 0, 0, 0, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 2'b00, 2'b00, 0, 0, 0);
        // SLVERR on the second beat, then a clean miss clears the flag
        run_miss(32'h2000_0008, 0, 0, 0, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 2'b00, 2'b10, 0, 0, 0);
        run_miss(32'h2000_0018, 0, 0, 0, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 2'b00, 2'b00, 0, 0, 0);
        // early rlast on the first beat, missing rlast on the second
        run_miss(32'h3000_0020, 0, 1, 0, 64'h9999_9999_9999_9999, 64'hEEEE_EEEE_EEEE_EEEE, 2'b00, 2'b00, 1, 0, 0);
        run_miss(32'h3000_0030, 2, 0, 1, 64'h1212_3434_5656_7878, 64'h9A9A_BCBC_DEDE_F0F0, 2'b00, 2'b00, 0, 1, 0);

        // reset while waiting for the second beat
        miss_req  = 1'b1;
        miss_addr = 32'h5000_0050;
        step();
        miss_req = 1'b0;
        arready  = 1'b1;
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 64'hABCD_ABCD_ABCD_ABCD;
        rlast   = 1'b0;
        step();
        rvalid = 1'b0;
        chk("in_r1_before_reset", {127'h0, rready}, 128'h1);
        rst_n = 1'b0;
        step();
        chk("midrst_ctrl", {124'h0, miss_ready, arvalid, rready, refill_valid}, {124'h0, 4'b1000});
        chk("midrst_line", refill_line, 128'h0);
        chk("midrst_addrs", {64'h0, araddr, refill_addr}, 128'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_strobe", {126'h0, refill_valid, miss_ready}, 128'h1);
        end

        // randomized refills
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            run_miss(ra, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     {$urandom, $urandom}, {$urandom, $urandom},
                     ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
